snitch_asic_dw_converter: RTL



---
 rtl/snitch_asic_dw_converter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/snitch_asic_dw_converter.sv
// snitch_asic_dw_converter: bridges a 32b core port to the narrow ASIC link.
// One transaction in flight; nibbles travel MSB first in both directions.
module snitch_asic_dw_converter #(
  parameter int unsigned AsicAW    = 8,
  parameter int unsigned AsicDW    = 4,
  parameter int unsigned MemDW     = 32,
  parameter int unsigned Stages    = MemDW / AsicDW,
  parameter int unsigned StrbWidth = MemDW / 8,
  parameter int unsigned CoreAW    = AsicAW - $clog2(Stages)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CoreAW-1:0]    core_req_addr_i,
  input  logic [MemDW-1:0]     core_req_data_i,
  input  logic                 core_req_write_i,
  input  logic [StrbWidth-1:0] core_req_strb_i,
  input  logic                 core_req_valid_i,
  output logic                 core_req_ready_o,
  output logic [MemDW-1:0]     core_rsp_data_o,
  output logic                 core_rsp_valid_o,
  input  logic                 core_rsp_ready_i,
  output logic [AsicAW-1:0]    asic_req_addr_o,
  output logic [AsicDW-1:0]    asic_req_data_o,
  output logic                 asic_req_write_o,
  output logic                 asic_req_wstrb_o,
  output logic                 asic_req_valid_o,
  input  logic                 asic_req_ready_i,
  input  logic [AsicDW-1:0]    asic_rsp_data_i,
  input  logic                 asic_rsp_last_i,
  input  logic                 asic_rsp_valid_i,
  output logic                 asic_rsp_ready_o
);

  localparam int unsigned KW = $clog2(Stages);
  localparam int unsigned CW = $clog2(Stages + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    CRSP
  } state_e;

  state_e               state_q, state_d;
  logic [CoreAW-1:0]    addr_q, addr_d;
  logic [MemDW-1:0]     wdata_q, wdata_d;
  logic [StrbWidth-1:0] strb_q, strb_d;
  logic                 write_q, write_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [MemDW-1:0]     acc_q, acc_d;
  logic                 live_q;

  // k counts nibbles from the MSB; kr counts them from the LSB
  logic [KW-1:0]        kr;
  assign kr = ~k_q;

  // keeps the core port closed while reset is held and on its release edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  // state and transaction registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      write_q <= write_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // next-state and output decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    write_d = write_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;

    core_req_ready_o = 1'b0;
    core_rsp_valid_o = 1'b0;
    core_rsp_data_o  = '0;
    asic_req_valid_o = 1'b0;
    asic_req_addr_o  = '0;
    asic_req_data_o  = '0;
    asic_req_write_o = 1'b0;
    asic_req_wstrb_o = 1'b0;
    asic_rsp_ready_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        core_req_ready_o = live_q;
        if (core_req_valid_i && live_q) begin
          addr_d  = core_req_addr_i;
          wdata_d = core_req_data_i;
          strb_d  = core_req_strb_i;
          write_d = core_req_write_i;
          k_d     = '0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        asic_req_valid_o = 1'b1;
        asic_req_addr_o  = {addr_q, k_q};
        if (write_q) begin
          asic_req_write_o = 1'b1;
          asic_req_data_o  =
            AsicDW'(wdata_q >> (kr * AsicDW));
          asic_req_wstrb_o =
            1'(strb_q >> ((kr * AsicDW + AsicDW - 1) / 8));
        end
        if (asic_req_ready_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        asic_rsp_ready_o = 1'b1;
        if (asic_rsp_valid_i) begin
          acc_d = {acc_q[MemDW-AsicDW-1:0], asic_rsp_data_i};
          cnt_d = cnt_q + 1'b1;
          if (asic_rsp_last_i || cnt_q == CW'(Stages - 1)) begin
            if (!write_q || k_q == KW'(Stages - 1)) begin
              state_d = CRSP;
            end else begin
              k_d     = k_q + 1'b1;
              cnt_d   = '0;
              state_d = REQ;
            end
          end
        end
      end
      CRSP: begin
        core_rsp_valid_o = 1'b1;
        core_rsp_data_o  = write_q ? '0 : acc_q;
        if (core_rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
